// File: rtl/prog_loader.sv
// Program loader: accepts HDR/LEN/payload/CSUM frames, writes the payload into
// instruction RAM from address 0 and holds the cpu in reset until a good frame lands.
module prog_loader #(
  parameter int         ADDR_W  = 8,
  parameter int         MAX_LEN = 255,
  parameter logic [7:0] HDR     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              load_ok,
  output logic              load_err,
  output logic [7:0]        loaded_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t     state, state_next;
  logic [7:0] len, count, sum;
  logic       accept, len_bad;

  assign accept  = in_valid & in_ready;
  assign len_bad = (in_data == 8'd0) || ({1'b0, in_data} > MAX_LEN_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Only an accepted byte may move the FSM; a HDR inside DATA is ordinary payload.
  always_comb begin
    state_next = state;
    if (accept) begin
      unique case (state)
        S_IDLE:  if (in_data == HDR) state_next = S_LEN;
        S_LEN:   state_next = len_bad ? S_ERROR : S_DATA;
        S_DATA:  if (count == len - 8'd1) state_next = S_CSUM;
        S_CSUM:  state_next = (in_data == sum) ? S_DONE : S_ERROR;
        S_DONE,
        S_ERROR: if (in_data == HDR) state_next = S_LEN;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      cpu_reset  <= 1'b1;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
      loaded_len <= 8'd0;
      len        <= 8'd0;
      count      <= 8'd0;
      sum        <= 8'd0;
    end else begin
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      if (accept && state == S_LEN && !len_bad) begin
        len   <= in_data;
        count <= 8'd0;
        sum   <= 8'd0;
      end
      if (accept && state == S_DATA) begin
        mem_we    <= 1'b1;
        mem_addr  <= ADDR_W'(count);
        mem_wdata <= in_data;
        sum       <= sum + in_data;
        count     <= count + 8'd1;
      end
      // Status flags and cpu reset change only on entry to LEN, DONE or ERROR.
      if (state_next != state) begin
        unique case (state_next)
          S_LEN: begin
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            cpu_reset <= 1'b1;
          end
          S_DONE: begin
            load_ok    <= 1'b1;
            load_err   <= 1'b0;
            loaded_len <= len;
            cpu_reset  <= 1'b0;
          end
          S_ERROR: begin
            load_ok   <= 1'b0;
            load_err  <= 1'b1;
            cpu_reset <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected RAM writes are queued as bytes are sent
// and checked as mem_we pulses appear; status outputs are checked after each frame.
module tb_prog_loader;

  localparam int ADDR_W  = 8;
  localparam int MAX_LEN = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_reset;
  logic              load_ok;
  logic              load_err;
  logic [7:0]        loaded_len;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .HDR(8'hA5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .load_ok    (load_ok),
    .load_err   (load_err),
    .loaded_len (loaded_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; the byte is accepted on the next rising edge.
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    logic [7:0] s;
    logic [7:0] d;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset values
    #20;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_load_ok", 32'(load_ok), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_loaded_len", 32'(loaded_len), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    idle(1);
    check("ready_after_edge", 32'(in_ready), 32'd1);
    check("cpu_reset_idle", 32'(cpu_reset), 32'd1);

    // Good frame
    push(8'd0, 8'h11); push(8'd1, 8'h22); push(8'd2, 8'h33);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("csum_pending_cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'h66);
    check("good_load_ok", 32'(load_ok), 32'd1);
    check("good_load_err", 32'(load_err), 32'd0);
    check("good_loaded_len", 32'(loaded_len), 32'd3);
    check("good_cpu_reset", 32'(cpu_reset), 32'd0);

    // Non-HDR byte in DONE is ignored
    send(8'h33);
    check("done_ignore_ok", 32'(load_ok), 32'd1);
    check("done_ignore_cpu", 32'(cpu_reset), 32'd0);

    // Bad checksum, then a good one-byte frame
    send(8'hA5);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_load_ok", 32'(load_ok), 32'd0);
    push(8'd0, 8'h10); push(8'd1, 8'h20);
    send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    check("badsum_load_err", 32'(load_err), 32'd1);
    check("badsum_load_ok", 32'(load_ok), 32'd0);
    check("badsum_cpu_reset", 32'(cpu_reset), 32'd1);
    check("badsum_loaded_len", 32'(loaded_len), 32'd3);
    push(8'd0, 8'hE0);
    send(8'hA5);
    check("err_hdr_clears_err", 32'(load_err), 32'd0);
    send(8'h01); send(8'hE0); send(8'hE0);
    check("len1_load_ok", 32'(load_ok), 32'd1);
    check("len1_load_err", 32'(load_err), 32'd0);
    check("len1_cpu_reset", 32'(cpu_reset), 32'd0);
    check("len1_loaded_len", 32'(loaded_len), 32'd1);

    // Bad lengths: zero, FF, and MAX_LEN+1
    send(8'hA5); send(8'h00);
    check("len0_load_err", 32'(load_err), 32'd1);
    check("len0_cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'hA5); send(8'hFF);
    check("lenff_load_err", 32'(load_err), 32'd1);
    send(8'hA5); send(8'(MAX_LEN + 1));
    check("lenmax1_load_err", 32'(load_err), 32'd1);
    idle(2);

    // Largest accepted length
    s = 8'h00;
    send(8'hA5); send(8'(MAX_LEN));
    for (int i = 0; i < MAX_LEN; i++) begin
      d = 8'($urandom_range(0, 255));
      push(8'(i), d);
      s = s + d;
      send(d);
    end
    send(s);
    check("maxlen_load_ok", 32'(load_ok), 32'd1);
    check("maxlen_loaded_len", 32'(loaded_len), 32'(MAX_LEN));
    check("maxlen_cpu_reset", 32'(cpu_reset), 32'd0);

    // Gaps between bytes, HDR value as payload
    push(8'd0, 8'hA5); push(8'd1, 8'h01);
    send(8'hA5); idle(3);
    check("gap_ready", 32'(in_ready), 32'd1);
    check("gap_cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'h02); idle(3);
    send(8'hA5); idle(3);
    check("gap_no_restart_ok", 32'(load_ok), 32'd0);
    send(8'h01); idle(3);
    check("gap_mem_we_low", 32'(mem_we), 32'd0);
    send(8'hA6);
    check("gap_load_ok", 32'(load_ok), 32'd1);
    check("gap_loaded_len", 32'(loaded_len), 32'd2);
    check("gap_cpu_reset_low", 32'(cpu_reset), 32'd0);

    // Reload then reset mid-frame
    send(8'hA5);
    check("reload2_cpu_reset", 32'(cpu_reset), 32'd1);
    push(8'd0, 8'h77);
    send(8'h02); send(8'h77);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("midrst_load_ok", 32'(load_ok), 32'd0);
    check("midrst_loaded_len", 32'(loaded_len), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    send(8'h02);
    send(8'h5A);
    push(8'd0, 8'h5A); push(8'd1, 8'hC3);
    send(8'hA5); send(8'h02); send(8'h5A); send(8'hC3); send(8'h1D);
    check("post_rst_load_ok", 32'(load_ok), 32'd1);
    check("post_rst_loaded_len", 32'(loaded_len), 32'd2);
    check("post_rst_cpu_reset", 32'(cpu_reset), 32'd0);

    idle(2);
    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Program loader upstream of the cpu/instruction-memory pair.
- Receives a framed byte stream over a valid/ready handshake.
- Writes the payload into the writable instruction RAM starting at address 0.
- Holds the cpu in reset until a complete frame with a matching checksum has been loaded, then releases it.
- Any new header byte reloads the program and re-asserts cpu reset.

Parameters:
ADDR_W, 8, instruction RAM address width (matches 8-bit pc)
MAX_LEN, 255, largest accepted payload length in bytes (must be ≤ 2^ADDR_W - 1 and ≤ 255)
HDR, 8'hA5, frame start byte

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in_data  input  8  incoming stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
mem_we  output  1  instruction RAM write strobe, one cycle per payload byte
mem_addr  output  ADDR_W  RAM write address
mem_wdata  output  8  RAM write data
cpu_reset  output  1  active-high reset driven to the cpu
load_ok  output  1  last frame loaded with good checksum
load_err  output  1  last frame rejected (bad length or checksum)
loaded_len  output  8  payload length of the last good frame

Behaviour:
Async reset (reset_n=0):
- State = IDLE.
- in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- cpu_reset=1, load_ok=0, load_err=0, loaded_len=0.
- Counters and checksum cleared.

Handshake:
- in_ready=1 in every state after reset deasserts; it is registered and goes 1 on the first clk edge after reset release.
- The loader never back-pressures. The port exists for upstream FIFO compatibility.

Frame format: HDR, LEN, LEN payload bytes, CSUM.
- CSUM = 8-bit modulo-256 sum of the payload bytes.

State machine (one transition per accepted byte only):
- IDLE: byte==HDR → LEN. Other bytes are discarded.
- LEN: LEN==0 or LEN>MAX_LEN → ERROR. Otherwise store LEN, clear count and sum → DATA.
- DATA:
  - Each accepted byte registers mem_we=1, mem_addr=count, mem_wdata=byte on the following cycle (1-cycle latency).
  - sum += byte (8-bit wrap); count++.
  - When count reaches LEN-1 on an accept → CSUM.
  - A byte equal to HDR inside DATA is payload, not a restart.
- CSUM:
  - byte==sum → DONE: load_ok=1, load_err=0, loaded_len=LEN; cpu_reset falls to 0 on the same edge.
  - byte!=sum → ERROR: load_err=1, load_ok=0, cpu_reset stays 1.
- DONE: cpu runs. byte==HDR → LEN, cpu_reset=1 and load_ok=0 on that edge. Other bytes are ignored.
- ERROR: cpu_reset=1. byte==HDR → LEN and load_err clears. Other bytes are ignored.

Other rules:
- mem_we is a single-cycle pulse; it is 0 in every cycle without a preceding DATA accept.
- RAM contents are not cleared on error. The cpu never leaves reset until a good frame completes.
- Entering LEN from any state clears load_ok and load_err.
- Reset mid-frame: everything returns to reset values, cpu_reset=1. The partial frame is abandoned and a fresh HDR is required.
- in_valid low in any state: no state, counter or output change. mem_we returns to 0.

Test Plan:
- Reset: hold reset_n=0 for 20 ns → cpu_reset=1, in_ready=0, mem_we=0, load_ok=0, load_err=0. After release, in_ready=1 within 1 cycle.
- Good frame A5,03,11,22,33,66 → three mem_we pulses writing addr0=11, addr1=22, addr2=33. After the 66 byte: load_ok=1, loaded_len=3, cpu_reset=0.
- Bad checksum A5,02,10,20,31 → two writes occur, then load_err=1, cpu_reset stays 1. A following good frame A5,01,E0,E0 → load_ok=1, load_err=0, cpu_reset=0.
- Bad length A5,00 → ERROR, load_err=1, no mem_we. Repeat with LEN=FF while MAX_LEN=16 → same result.
- Gaps and payload HDR: A5,02,A5,01,A6 with in_valid dropped for 3 cycles between each byte → writes A5@0, 01@1, load_ok=1. No state change during the gaps.
- Reload and mid-frame reset: in DONE, send A5 → cpu_reset=1 next edge. Assert reset_n=0 after 1 payload byte → all outputs at reset values. A following clean frame loads correctly.
